fpu_arbiter: RTL and testbench
==============================

Name: fpu_arbiter

Overview:
Sequencing controller and 2-way round-robin arbiter in front of one shared Fixed_Point_Unit instance. It accepts operation requests from two requesters over valid/ready handshakes and latches the operands. It drives the FPU until `ready`, or until a watchdog timeout fires, then returns the result with the requester id. It also guarantees the FPU's multi-cycle MUL/SQRT stage machines are cleared between consecutive operations.

Parameters:
WIDTH, 32, operand/result width; must match the FPU instance.
TIMEOUT, 64, max cycles in EXEC before abort; 2..255.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (reset==0 asserts)
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 request accepted this cycle
req0_op  in  2  `FPU_ADD/`FPU_SUB/`FPU_MUL/`FPU_SQRT
req0_a  in  WIDTH  operand 1
req0_b  in  WIDTH  operand 2 (ignored for SQRT)
req1_valid, req1_ready, req1_op, req1_a, req1_b: same for requester 1
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester that issued the op
rsp_result  out  WIDTH  FPU result (0 on timeout)
rsp_error  out  1  1 = watchdog timeout
fpu_operand_1  out  WIDTH  to FPU operand_1
fpu_operand_2  out  WIDTH  to FPU operand_2
fpu_operation  out  2  to FPU operation
fpu_result  in  WIDTH  from FPU result
fpu_ready  in  1  from FPU ready
busy  out  1  state != IDLE

Behaviour:
- Interface: one clock `clk`. `reset` is asynchronous and active-low. All state is registered.
- Reset values:
  - state=IDLE, rr pointer=0, timer=0.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_error=0, busy=0.
  - Operand registers are 0; fpu_operation=`FPU_ADD.
- Reset mid-operation aborts it immediately. The in-flight op is lost and no response is produced.
- States:
  - IDLE: req*_ready combinational = grant & state==IDLE.
    - If any valid: capture op/a/b/id of the granted requester; go to EXEC.
    - Grant is round-robin. If both requesters are valid, grant the one the pointer selects. If only one is valid, grant it.
    - After each grant, the pointer points to the non-granted requester.
  - EXEC: fpu_operation=latched op; fpu_operand_1/2=latched a/b. The timer increments each cycle.
    - If fpu_ready=1: rsp_result<=fpu_result, rsp_error<=0; go to RESP.
    - Else, if timer==TIMEOUT-1: rsp_result<=0, rsp_error<=1; go to RESP.
    - fpu_ready takes precedence over timeout in the same cycle.
  - RESP: rsp_valid=1; rsp_id/result/error are held stable.
    - If rsp_ready=1: go to IDLE and clear the timer.
    - rsp_valid must not drop and payload must not change until accepted.
- Outside EXEC, fpu_operation is forced to `FPU_ADD (harmless, combinational). This guarantees at least one clock edge with operation≠MUL/SQRT between operations, which resets the FPU stage machines and clears stale root/product ready.
- Operands outside EXEC hold the last latched values; no X/Z is ever driven.
- Latency (request-accept edge to rsp_valid): ADD/SUB = 2 cycles. MUL/SQRT = 1 + FPU latency + 1.
- Back-to-back throughput: minimum 3 cycles per op (IDLE, EXEC, RESP).
- A requester may hold valid with changing payload while not granted; only the value at the accept edge is used.
- Illegal op codes cannot occur (2-bit field fully decoded).

Decomposition:
- Shared defines (existing Defines.vh): `FPU_ADD/SUB/MUL/SQRT encodings.
- Add state encodings FPU_ARB_IDLE/EXEC/RESP as localparams.
- One natural sub-module: rr_arbiter_2. Ports: clk, reset, req[1:0], advance, grant[1:0], pointer flip on advance.

Test Plan:
1. req0 ADD a=0x00000600 (1.5), b=0x00000800 (2.0), rsp_ready=1 -> rsp_valid 2 cycles after accept, result=0x00000E00, id=0, error=0.
2. req1 MUL a=0x600, b=0x800 (FBITS=10) -> result=0x00000C00 (3.0), id=1; fpu_operation=`FPU_ADD in the cycle after EXEC.
3. Both valid every cycle, 4 SUB ops each -> grants alternate 0,1,0,1…; no requester is granted twice in a row; all 8 responses are correct.
4. SQRT a=0x1000 (4.0) then immediately SQRT a=0x2400 (9.0) -> results 0x800 then 0xC00; the second is not contaminated by stale root_ready.
5. FPU stub holding fpu_ready=0, TIMEOUT=8 -> rsp_valid after 8 EXEC cycles with result=0, error=1; the next request completes normally.
6. rsp_ready=0 for 5 cycles, and separately reset pulsed low during EXEC -> response is held stable and then accepted; reset returns all outputs to reset values asynchronously, and no response is emitted for the aborted op.

Source files
------------

// File: rtl/fpu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// fpu_arbiter_pkg : FPU op encodings, arbiter state codes, round-robin helper
// Rev 1.0
// ============================================================================
package fpu_arbiter_pkg;

    localparam logic [1:0] FPU_ADD  = 2'b00;
    localparam logic [1:0] FPU_SUB  = 2'b01;
    localparam logic [1:0] FPU_MUL  = 2'b10;
    localparam logic [1:0] FPU_SQRT = 2'b11;

    localparam logic [1:0] FPU_ARB_IDLE = 2'd0;
    localparam logic [1:0] FPU_ARB_EXEC = 2'd1;
    localparam logic [1:0] FPU_ARB_RESP = 2'd2;

    // pointer = 0 favours requester 0 when both are asking
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic pointer);
        logic [1:0] grant;
        if (req == 2'b11) begin
            grant = pointer ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
        return grant;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_arbiter_rr_arbiter_2.sv
`default_nettype none
// ============================================================================
// rr_arbiter_2 : two-way round-robin grant with a registered priority pointer
// Rev 1.0
// ============================================================================
module rr_arbiter_2
    import fpu_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic r_pointer;

    always_comb begin
        grant = rr_pick(req, r_pointer);
    end

    // After a grant the pointer moves to the requester that lost
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pointer <= 1'b0;
        end else if (advance && (grant != 2'b00)) begin
            r_pointer <= grant[0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpu_arbiter.sv
`default_nettype none
// ============================================================================
// fpu_arbiter : two-requester sequencer in front of a shared Fixed_Point_Unit
// Rev 1.0
// ============================================================================
module fpu_arbiter
    import fpu_arbiter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_error,
    output logic [WIDTH-1:0] fpu_operand_1,
    output logic [WIDTH-1:0] fpu_operand_2,
    output logic [1:0]       fpu_operation,
    input  logic [WIDTH-1:0] fpu_result,
    input  logic             fpu_ready,
    output logic             busy
);

    localparam logic [7:0] c_timer_last = 8'(TIMEOUT - 1);

    logic [1:0]       r_state;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_id;
    logic [7:0]       r_timer;
    logic [WIDTH-1:0] r_result;
    logic             r_error;

    logic [1:0]       w_grant;
    logic             w_idle;
    logic             w_accept;

    assign w_idle   = (r_state == FPU_ARB_IDLE);
    assign w_accept = w_idle && (w_grant != 2'b00);

    rr_arbiter_2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     ({req1_valid, req0_valid}),
        .advance (w_accept),
        .grant   (w_grant)
    );

    assign req0_ready = w_idle && w_grant[0];
    assign req1_ready = w_idle && w_grant[1];

    // Forcing ADD outside EXEC gives the FPU one edge to drop its MUL/SQRT stage state
    assign fpu_operation = (r_state == FPU_ARB_EXEC) ? r_op : FPU_ADD;
    assign fpu_operand_1 = r_a;
    assign fpu_operand_2 = r_b;

    assign rsp_valid  = (r_state == FPU_ARB_RESP);
    assign rsp_id     = r_id;
    assign rsp_result = r_result;
    assign rsp_error  = r_error;
    assign busy       = !w_idle;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= FPU_ARB_IDLE;
            r_op     <= FPU_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_id     <= 1'b0;
            r_timer  <= 8'd0;
            r_result <= '0;
            r_error  <= 1'b0;
        end else begin
            case (r_state)
                FPU_ARB_IDLE: begin
                    if (w_accept) begin
                        r_op    <= w_grant[1] ? req1_op : req0_op;
                        r_a     <= w_grant[1] ? req1_a  : req0_a;
                        r_b     <= w_grant[1] ? req1_b  : req0_b;
                        r_id    <= w_grant[1];
                        r_state <= FPU_ARB_EXEC;
                    end
                end
                FPU_ARB_EXEC: begin
                    r_timer <= r_timer + 8'd1;
                    if (fpu_ready) begin
                        r_result <= fpu_result;
                        r_error  <= 1'b0;
                        r_state  <= FPU_ARB_RESP;
                    end else if (r_timer == c_timer_last) begin
                        r_result <= '0;
                        r_error  <= 1'b1;
                        r_state  <= FPU_ARB_RESP;
                    end
                end
                FPU_ARB_RESP: begin
                    if (rsp_ready) begin
                        r_timer <= 8'd0;
                        r_state <= FPU_ARB_IDLE;
                    end
                end
                default: begin
                    r_state <= FPU_ARB_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_arbiter.sv
`default_nettype none
// ============================================================================
// tb_fpu_arbiter : directed bench with FPU stub and response scoreboard
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_fpu_arbiter;
    import fpu_arbiter_pkg::*;

    localparam int WIDTH    = 32;
    localparam int TIMEOUT  = 8;
    localparam int MUL_LAT  = 3;
    localparam int SQRT_LAT = 4;

    typedef struct packed {
        logic        id;
        logic [31:0] res;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic req0_valid = 1'b0, req1_valid = 1'b0;
    logic req0_ready, req1_ready;
    logic [1:0] req0_op = FPU_ADD, req1_op = FPU_ADD;
    logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_error;
    logic [WIDTH-1:0] rsp_result;
    logic [WIDTH-1:0] fpu_operand_1, fpu_operand_2, fpu_result;
    logic [1:0] fpu_operation;
    logic fpu_ready, busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fpu_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_error(rsp_error),
        .fpu_operand_1(fpu_operand_1), .fpu_operand_2(fpu_operand_2), .fpu_operation(fpu_operation),
        .fpu_result(fpu_result), .fpu_ready(fpu_ready), .busy(busy)
    );

    // Q21.10 reference arithmetic
    function automatic logic [31:0] fx_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p, x, r, t;
        case (op)
            FPU_ADD: return a + b;
            FPU_SUB: return a - b;
            FPU_MUL: begin
                p = {32'd0, a} * {32'd0, b};
                return p[41:10];
            end
            default: begin
                x = {32'd0, a} << 10;
                r = 64'd0;
                for (int i = 31; i >= 0; i--) begin
                    t = r | (64'd1 << i);
                    if (t * t <= x) r = t;
                end
                return r[31:0];
            end
        endcase
    endfunction

    // FPU stub: MUL/SQRT stage counter clears whenever the op is not MUL/SQRT
    logic [3:0] stub_cnt;
    logic       stub_hang = 1'b0;
    always @(posedge clk or negedge reset) begin
        if (!reset) stub_cnt <= 4'd0;
        else if (fpu_operation == FPU_MUL || fpu_operation == FPU_SQRT)
            stub_cnt <= (stub_cnt == 4'd15) ? stub_cnt : stub_cnt + 4'd1;
        else stub_cnt <= 4'd0;
    end
    always_comb begin
        fpu_result = fx_model(fpu_operation, fpu_operand_1, fpu_operand_2);
        if (stub_hang) fpu_ready = 1'b0;
        else if (fpu_operation == FPU_MUL) fpu_ready = (stub_cnt >= 4'(MUL_LAT));
        else if (fpu_operation == FPU_SQRT) fpu_ready = (stub_cnt >= 4'(SQRT_LAT));
        else fpu_ready = 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor / scoreboard, sampled on the falling edge
    exp_t        sb_q[$];
    logic [31:0] rsp_log[$];
    logic        last_id, last_err;
    int          cyc = 0, acc_cyc = 0, last_lat = 0;
    logic        lat_pending = 1'b0;
    logic        last_grant = 1'b1;
    logic        hold = 1'b0;
    logic [33:0] hold_payload;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            sb_q.delete();
            hold = 1'b0;
            lat_pending = 1'b0;
            last_grant = 1'b1;
        end else begin
            if (req0_ready || req1_ready)
                check("ready_onehot", {63'd0, req0_ready && req1_ready}, 64'd0);
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                exp_t e;
                e.id = req1_valid && req1_ready;
                if (req0_valid && req1_valid)
                    check("rr_alternate", {63'd0, e.id}, {63'd0, ~last_grant});
                last_grant = e.id;
                e.err = stub_hang;
                e.res = stub_hang ? 32'd0 :
                        (e.id ? fx_model(req1_op, req1_a, req1_b) : fx_model(req0_op, req0_a, req0_b));
                sb_q.push_back(e);
                acc_cyc = cyc;
                lat_pending = 1'b1;
            end
            if (hold) begin
                check("hold_valid", {63'd0, rsp_valid}, 64'd1);
                check("hold_payload", {30'd0, rsp_id, rsp_error, rsp_result}, {30'd0, hold_payload});
            end
            if (rsp_valid) begin
                check("op_forced_add", {62'd0, fpu_operation}, {62'd0, FPU_ADD});
                if (lat_pending) begin
                    last_lat = cyc - acc_cyc;
                    lat_pending = 1'b0;
                end
                if (rsp_ready) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check("rsp_id", {63'd0, rsp_id}, {63'd0, e.id});
                        check("rsp_result", {32'd0, rsp_result}, {32'd0, e.res});
                        check("rsp_error", {63'd0, rsp_error}, {63'd0, e.err});
                        rsp_log.push_back(rsp_result);
                        last_id = rsp_id;
                        last_err = rsp_error;
                    end
                end
            end
            hold = rsp_valid && !rsp_ready;
            hold_payload = {rsp_id, rsp_error, rsp_result};
        end
    end

    task automatic issue(input logic id, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bit got = 1'b0;
        @(posedge clk); #1;
        if (id) begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; end
        else    begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; end
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
        end
        if (!got) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = !busy && (sb_q.size() == 0);
        end
        if (!done) check("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int n0, n1, rsp_seen;
        bit g0, g1;

        // Reset values
        #2;
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_payload", {30'd0, rsp_id, rsp_error, rsp_result}, 64'd0);
        check("rst_fpu_op", {62'd0, fpu_operation}, {62'd0, FPU_ADD});
        check("rst_operands", {fpu_operand_1, fpu_operand_2}, 64'd0);
        @(negedge clk); reset = 1'b1;

        // 1: ADD 1.5 + 2.0
        rsp_log.delete();
        issue(1'b0, FPU_ADD, 32'h600, 32'h800);
        wait_done();
        check("t1_result", {32'd0, rsp_log[0]}, 64'hE00);
        check("t1_id", {63'd0, last_id}, 64'd0);
        check("t1_latency", 64'(last_lat), 64'd2);

        // 2: MUL 1.5 * 2.0 from requester 1
        rsp_log.delete();
        issue(1'b1, FPU_MUL, 32'h600, 32'h800);
        wait_done();
        check("t2_result", {32'd0, rsp_log[0]}, 64'hC00);
        check("t2_id", {63'd0, last_id}, 64'd1);
        check("t2_latency", 64'(last_lat), 64'(1 + MUL_LAT + 1));

        // 3: both requesters contending, 4 SUBs each
        n0 = 0; n1 = 0;
        @(posedge clk); #1;
        req0_op = FPU_SUB; req0_a = 32'h5000; req0_b = 32'h100;
        req1_op = FPU_SUB; req1_a = 32'h3000; req1_b = 32'h3400;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int c = 0; c < 200 && (n0 < 4 || n1 < 4); c++) begin
            @(negedge clk);
            g0 = req0_valid && req0_ready;
            g1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            if (g0) begin
                n0++;
                if (n0 < 4) begin req0_a = 32'h5000 + 32'(n0) * 32'h340; req0_b = 32'(n0 + 1) * 32'h100; end
                else req0_valid = 1'b0;
            end
            if (g1) begin
                n1++;
                if (n1 < 4) begin req1_a = 32'h3000 + 32'(n1) * 32'h80; req1_b = 32'h200 * 32'(n1); end
                else req1_valid = 1'b0;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("t3_grants", {32'(n0), 32'(n1)}, {32'd4, 32'd4});
        wait_done();

        // 4: back-to-back SQRTs
        rsp_log.delete();
        issue(1'b0, FPU_SQRT, 32'h1000, 32'h0);
        issue(1'b0, FPU_SQRT, 32'h2400, 32'h0);
        wait_done();
        check("t4_count", 64'(rsp_log.size()), 64'd2);
        check("t4_sqrt4", {32'd0, rsp_log[0]}, 64'h800);
        check("t4_sqrt9", {32'd0, rsp_log[1]}, 64'hC00);

        // 5: FPU never ready -> watchdog, then a normal op
        rsp_log.delete();
        stub_hang = 1'b1;
        issue(1'b1, FPU_ADD, 32'h400, 32'h400);
        wait_done();
        stub_hang = 1'b0;
        check("t5_err", {63'd0, last_err}, 64'd1);
        check("t5_result", {32'd0, rsp_log[0]}, 64'd0);
        check("t5_latency", 64'(last_lat), 64'(1 + TIMEOUT));
        issue(1'b0, FPU_ADD, 32'h400, 32'h400);
        wait_done();
        check("t5_recover", {32'd0, rsp_log[1]}, 64'h800);
        check("t5_recover_err", {63'd0, last_err}, 64'd0);

        // 6a: consumer stalls for 5 cycles
        rsp_log.delete();
        rsp_ready = 1'b0;
        issue(1'b0, FPU_ADD, 32'h100, 32'h200);
        repeat (5) @(negedge clk);
        check("t6_stalled_valid", {63'd0, rsp_valid}, 64'd1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_done();
        check("t6_stall_result", {32'd0, rsp_log[0]}, 64'h300);

        // 6b: async reset during EXEC
        issue(1'b1, FPU_MUL, 32'h800, 32'h800);
        check("t6_in_exec", {63'd0, busy}, 64'd1);
        #2; reset = 1'b0;
        #1;
        check("t6_rst_busy", {63'd0, busy}, 64'd0);
        check("t6_rst_rsp", {62'd0, rsp_valid, rsp_error}, 64'd0);
        check("t6_rst_payload", {31'd0, rsp_id, rsp_result}, 64'd0);
        check("t6_rst_op", {62'd0, fpu_operation}, {62'd0, FPU_ADD});
        check("t6_rst_operands", {fpu_operand_1, fpu_operand_2}, 64'd0);
        @(negedge clk);
        @(posedge clk); #1; reset = 1'b1;
        rsp_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        check("t6_no_rsp", 64'(rsp_seen), 64'd0);
        rsp_log.delete();
        issue(1'b0, FPU_SUB, 32'h900, 32'h100);
        wait_done();
        check("t6_after_rst", {32'd0, rsp_log[0]}, 64'h800);
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
